uart_tx: RTL and testbench

- Serial transmitter for the FPGA UART; the outbound counterpart of the receive path.
- Accepts parallel bytes over a valid/ready handshake and serialises them onto the TX line as 8N1/8N2 frames (optionally 8E1/8E2).
- Runs entirely in the system clock domain.
- Its tx_o pin is what the remote receiver samples and synchronises.

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, serialised LSB first as start/data/stop frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  // Handshake contract: a byte transfers on the clk_i edge where valid_i && ready_o;
  // valid_i may stay high across frames, and valid_i while busy is ignored.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tx;
  logic                 busy;
  logic                 done;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign ready_o = (state == IDLE);
  assign tx_o    = tx;
  assign busy_o  = busy;
  assign done_o  = done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // The baud counter free-runs within a bit and reloads on every bit boundary.
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (valid_i) begin
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= data_i;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data_i;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          // bit_cnt is reused here to count stop-bit periods.
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: hand-written frame table, directed corner cases and random bytes
// checked cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int STOPB = 2;
  localparam int PBIT  = 1;
`else
  localparam int STOPB = 1;
  localparam int PBIT  = 0;
`endif
  localparam int NBITS = 1 + 8 + PBIT + STOPB;
  localparam int FRAME = NBITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(STOPB)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (data),
    .valid_i(valid),
    .ready_o(ready),
    .tx_o   (tx),
    .busy_o (busy),
    .done_o (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector is {tx, busy, done, ready}.
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {tx,busy,done,ready} got %b expected %b", name, act, exp);
    end
  endtask

  // Frame in transmission order; bit NBITS-1 goes on the line first.
  function automatic logic [NBITS-1:0] model_line(input logic [7:0] d);
    bit q[$];
    logic [NBITS-1:0] line;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back(^d);
`endif
    for (int s = 0; s < STOPB; s++) q.push_back(1'b1);
    for (int k = 0; k < NBITS; k++) line[NBITS-1-k] = q[k];
    return line;
  endfunction

  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle %0d", name, i), {tx, busy, done, ready}, 4'b1001);
    end
  endtask

  // Driver: called at a negedge with the DUT idle; runs one whole frame plus the done cycle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [NBITS-1:0] line,
                           input bit hold, input int alter_at, input logic [7:0] alter_data);
    logic [3:0] exp;
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= FRAME; j++) begin
      @(negedge clk);
      if (j < FRAME) exp = {line[NBITS-1-(j/CPB)], 3'b100};
      else           exp = 4'b1011;
      check($sformatf("%s d=%02h j=%0d", name, d, j), {tx, busy, done, ready}, exp);
      if (j == 0 && !hold) valid = 1'b0;
      if (j == alter_at) data = alter_data;
    end
  endtask

  typedef struct {
    logic [7:0]       data;
    logic [NBITS-1:0] line;
    bit               hold;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [7:0] d;
    bit h;
    int gap;

`ifdef UART_TX_PARITY_EN
    vecs.push_back('{8'h07, 12'b011100000111, 1'b0});
    vecs.push_back('{8'h03, 12'b011000000011, 1'b0});
    vecs.push_back('{8'hA5, 12'b010100101011, 1'b1});
    vecs.push_back('{8'hFF, 12'b011111111011, 1'b0});
`else
    vecs.push_back('{8'hA5, 10'b0101001011, 1'b0});
    vecs.push_back('{8'h00, 10'b0000000001, 1'b1});
    vecs.push_back('{8'hFF, 10'b0111111111, 1'b0});
    vecs.push_back('{8'h07, 10'b0111000001, 1'b0});
    vecs.push_back('{8'hC3, 10'b0110000111, 1'b0});
`endif

    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (5) @(negedge clk);
    check("in reset", {tx, busy, done, ready}, 4'b1001);
    rst_n = 1'b1;
    idle_cycles(100, "post reset");

    // table-driven frames; a held valid makes the next entry back-to-back
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_frame($sformatf("vec%0d", i), v.data, v.line, v.hold, -1, 8'h00);
    end
    idle_cycles(2, "after table");

    // data_i changes after the handshake must not reach the line
    run_frame("stability", 8'hC3, model_line(8'hC3), 1'b0, 2, 8'h3C);
    idle_cycles(1, "after stability");

    // back-to-back with valid held: 0x00 then 0xFF, one idle cycle in between
    run_frame("b2b first", 8'h00, model_line(8'h00), 1'b1, -1, 8'h00);
    run_frame("b2b second", 8'hFF, model_line(8'hFF), 1'b0, -1, 8'h00);
    idle_cycles(2, "after b2b");

    // reset in the middle of data bit 3 (line low for 0xA5)
    data  = 8'hA5;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (16) @(negedge clk);
    check("before abort bit3", {tx, busy, done, ready}, 4'b0100);
    #2 rst_n = 1'b0;
    #1 check("async abort", {tx, busy, done, ready}, 4'b1001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("held reset %0d", i), {tx, busy, done, ready}, 4'b1001);
    end
    rst_n = 1'b1;
    idle_cycles(3, "after abort");
    run_frame("post abort", 8'h55, model_line(8'h55), 1'b0, -1, 8'h00);
    idle_cycles(1, "after post abort");

    // random bytes, random hold, random late data changes and idle gaps
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      h = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", i), d, model_line(d), h,
                int'($urandom_range(0, FRAME - 1)), 8'($urandom_range(0, 255)));
      if (!h) begin
        gap = int'($urandom_range(0, 3));
        idle_cycles(gap, $sformatf("rand gap %0d", i));
      end
    end
    valid = 1'b0;
    idle_cycles(3, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
